// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display counter blocks.
package seg_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_PAUSE = 1'b1
  } state_e;

  localparam int unsigned CntMaxDefault = 24_999_999;
  localparam int unsigned DebCntDefault = 999_999;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low pushbutton conditioner: two-flop synchronizer, stability
// counter and a one-cycle press pulse on the debounced 1->0 transition.
module key_debounce
  import seg_pkg::*;
#(
  parameter int unsigned DEB_CNT = DebCntDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_press
);

  localparam int unsigned CntW = cnt_width(DEB_CNT);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CNT);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            press_q, press_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_in};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  // Count only while the synchronized level disagrees with the accepted one;
  // any return to agreement restarts qualification.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_q & ~level_d;
  end

  assign key_press = press_q;

endmodule

// File: rtl/tick_gen_ctrl.sv
// Prescaled increment-pulse generator with run/pause and single-step control
// for the hex-digit display stage.
module tick_gen_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned CNT_MAX = CntMaxDefault,
  parameter int unsigned DEB_CNT = DebCntDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_run,
  input  logic key_step,
  output logic add_flag,
  output logic running
);

  localparam int unsigned CntW = cnt_width(CNT_MAX);
  localparam logic [CntW-1:0] CntMax = CntW'(CNT_MAX);

  logic run_press, step_press;

  key_debounce #(.DEB_CNT(DEB_CNT)) u_key_run (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_run),
    .key_press(run_press)
  );

  key_debounce #(.DEB_CNT(DEB_CNT)) u_key_step (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_step),
    .key_press(step_press)
  );

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            add_flag_q, add_flag_d;
  // Holds the prescaler on the first edge after reset so that cnt equals the
  // edge number counted from reset release.
  logic            armed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      add_flag_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      add_flag_q <= add_flag_d;
      armed_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (run_press) state_d = ST_PAUSE;
      ST_PAUSE: if (run_press) state_d = ST_RUN;
    endcase
  end

  // A run press never suppresses the tick of the current state; in PAUSE it
  // wins over a coincident step press.
  always_comb begin
    cnt_d      = cnt_q;
    add_flag_d = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (armed_q) begin
          if (cnt_q == CntMax) begin
            cnt_d      = '0;
            add_flag_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_PAUSE: add_flag_d = step_press & ~run_press;
    endcase
  end

  assign add_flag = add_flag_q;
  assign running  = (state_q == ST_RUN);

endmodule

// File: tb/tb_tick_gen_ctrl.sv
// Directed bench for tick_gen_ctrl with CNT_MAX=9, DEB_CNT=3: a free-run
// prologue followed by a table of input segments with expected pulse counts.
module tb_tick_gen_ctrl;

  logic clk = 1'b0;
  logic rst_n, key_run, key_step;
  logic add_flag, running;

  int errors = 0;
  int checks = 0;

  tick_gen_ctrl #(
    .CNT_MAX(9),
    .DEB_CNT(3)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_run (key_run),
    .key_step(key_step),
    .add_flag(add_flag),
    .running (running)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        step;
    int unsigned n;
    int unsigned pulses;
    logic        running;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic kr, input logic ks, input int unsigned n,
                         input int unsigned p, input logic run_exp);
    vec_t v;
    v.rst_n = r; v.run = kr; v.step = ks; v.n = n; v.pulses = p; v.running = run_exp;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  initial begin
    int unsigned pulses;

    // Segment table; edge numbers in comments count from the first edge with rst_n=1.
    add_vec(1, 1, 1,  3, 0, 1);  // edges 35..37, cnt 5..7
    add_vec(1, 0, 1, 10, 1, 0);  // run press event -> pause at edge 44 with cnt=4
    add_vec(1, 1, 1, 50, 0, 0);  // paused, no ticks
    add_vec(1, 0, 1,  7, 0, 1);  // resume at edge 104
    add_vec(1, 1, 1,  5, 0, 1);  // cnt 5..9
    add_vec(1, 1, 1,  1, 1, 1);  // tick at edge 110
    add_vec(1, 0, 1,  7, 0, 0);  // pause at edge 117 with cnt=7
    add_vec(1, 1, 1, 10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      add_vec(1, 1, 0, 4, 0, 0);  // step press while paused
      add_vec(1, 1, 1, 8, 1, 0);  // one step tick
    end
    add_vec(1, 0, 1,  7, 0, 1);  // resume, cnt still 7
    add_vec(1, 1, 1,  2, 0, 1);  // cnt 8, 9
    add_vec(1, 1, 1,  1, 1, 1);  // tick T
    for (int i = 0; i < 3; i++) begin
      add_vec(1, 1, 0, 4, 0, 1);  // step presses in RUN are ignored
      add_vec(1, 1, 1, 8, 1, 1);  // regular ticks at T+10, T+20, T+30
    end
    add_vec(1, 0, 1,  2, 0, 1);  // bounce: 2 low / 2 high, T+37..T+56
    add_vec(1, 1, 1,  2, 1, 1);
    add_vec(1, 0, 1,  2, 0, 1);
    add_vec(1, 1, 1,  2, 0, 1);
    add_vec(1, 0, 1,  2, 0, 1);
    add_vec(1, 1, 1,  2, 0, 1);
    add_vec(1, 0, 1,  2, 1, 1);
    add_vec(1, 1, 1,  2, 0, 1);
    add_vec(1, 0, 1,  2, 0, 1);
    add_vec(1, 1, 1,  2, 0, 1);
    add_vec(1, 0, 1,  6, 1, 1);  // hold low; still running after 6 edges
    add_vec(1, 0, 1,  1, 0, 0);  // paused with cnt=3
    add_vec(1, 0, 1, 10, 0, 0);
    add_vec(1, 1, 1, 10, 0, 0);
    add_vec(1, 0, 0,  6, 0, 0);  // simultaneous run+step presses
    add_vec(1, 0, 0,  1, 0, 1);  // run wins, no step tick
    add_vec(1, 1, 1,  1, 0, 1);
    add_vec(1, 1, 1,  5, 0, 1);  // cnt 4..9
    add_vec(1, 1, 1,  1, 1, 1);  // tick F
    add_vec(1, 1, 1,  4, 0, 1);
    add_vec(1, 0, 0,  3, 0, 1);  // keys mid-debounce, cnt=7
    add_vec(0, 0, 0,  1, 0, 1);  // reset
    add_vec(1, 0, 0,  3, 0, 1);  // qualification restarts: too short for an event
    add_vec(1, 1, 1,  7, 0, 1);
    add_vec(1, 1, 1,  1, 1, 1);  // first tick after edge 10
    add_vec(1, 0, 1,  7, 0, 0);  // pause
    add_vec(0, 1, 1,  1, 0, 1);  // reset forces RUN

    rst_n = 1'b0; key_run = 1'b1; key_step = 1'b1;
    repeat (3) tick();
    check_bit("reset add_flag", add_flag, 1'b0);
    check_bit("reset running", running, 1'b1);

    rst_n = 1'b1;
    for (int k = 0; k < 35; k++) begin
      tick();
      check_bit($sformatf("freerun add_flag edge %0d", k), add_flag,
                (k == 10 || k == 20 || k == 30) ? 1'b1 : 1'b0);
    end
    check_bit("freerun running", running, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; key_run = vecs[i].run; key_step = vecs[i].step;
      pulses = 0;
      for (int c = 0; c < int'(vecs[i].n); c++) begin
        tick();
        if (add_flag === 1'b1) pulses++;
      end
      checks++;
      if (pulses != vecs[i].pulses) begin
        errors++;
        $display("FAIL vec%0d pulses: got %0d expected %0d", i, pulses, vecs[i].pulses);
      end
      check_bit($sformatf("vec%0d running", i), running, vecs[i].running);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
